pleiads_input_ctrl: RTL and testbench
=====================================

# pleiads_input_ctrl

Player-input front end for the Pleiads core. It sits between `hps_io` (the `ps2_key` event word and the OR'd joystick word) and the `phoenix` game core. It turns PS/2 make/break events into held key states and merges them with the joystick bits. It also shapes the coin input into a fixed-width pulse, so every insert registers with the game exactly once.

## Interface
Parameters:
- `COIN_HOLD`, default 176000: coin pulse width in `clk_sys` cycles (16 ms at 11 MHz); legal range 1..2^18-1.

Ports:
- `clk_sys`  in  1  system clock (11 MHz); the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of all key states and the coin FSM; driven during ROM download.
- `ps2_key`  in  11  bit 10 toggles once per event; bit 9 = pressed; bits 8:0 = scan code, bit 8 set for E0-extended codes.
- `joy`  in  16  joystick_0 OR joystick_1, bits active-high.
- `btn_left`, `btn_right`, `btn_fire`, `btn_barrier`  out  1 each  to the core.
- `btn_player_start`  out  2  bit 0 = 1P start, bit 1 = 2P start.
- `btn_coin`  out  1  shaped coin pulse.

## Operation
- Event detection:
  - The block keeps `tog_q` and an `armed` flag.
  - On the first edge after reset or `clear`, it loads `tog_q` from `ps2_key[10]`, sets `armed`, and decodes nothing.
  - Once armed, any edge with `ps2_key[10] != tog_q` is one event. That edge sets `tog_q` and writes `ps2_key[9]` into the matching key-state bit.
- Key map: the scan code selects which key-state bit is written. Unlisted codes are ignored.
  - Bit 8 is ignored for these codes: X75 up, X72 down, X6B left, X74 right, X14 ctrl (barrier).
  - Bit 8 must be 0 for all other codes:
    - 029 space (fire)
    - 005 and 016 (start 1)
    - 006 and 01E (start 2)
    - 02E (coin 1), 036 (coin 2)
    - 02D/02B (P2 up/down), 023/034 (P2 left/right)
    - 01C (P2 fire), 01B (P2 barrier)
- Merge, then register. Each output is registered from these terms:
  - `left` = key left | P2 left | `joy[1]`
  - `right` = key right | P2 right | `joy[0]`
  - `fire` = key fire | P2 fire | `joy[4]`
  - `barrier` = key ctrl | P2 barrier | `joy[5]`
  - `start[0]` = key start 1 | `joy[5]`
  - `start[1]` = key start 2 | `joy[6]`
  - Up and down keys are tracked in key state but are not output.
- Coin source: `coin_src` = coin1 | coin2 | `joy[7]`.
- Coin FSM:
  - IDLE: on `coin_src`=1, load the counter with `COIN_HOLD`-1 and go to HOLD.
  - HOLD: `btn_coin`=1. Decrement the counter each cycle; when it reaches 0, go to WAIT_REL.
  - WAIT_REL: `btn_coin`=0. When `coin_src`=0, go to IDLE.
  - Result: one pulse per press, whatever the press length. A source still held at the end of HOLD produces no second pulse.
  - Sources that overlap, such as key 5 held while `joy[7]` rises, count as one press.
- `clear` has priority over event decode and FSM advance:
  - All key-state bits go to 0; the FSM goes to IDLE with `btn_coin`=0; `armed` goes to 0.
  - Joystick terms still reach the outputs one cycle later.

## Timing
- Reset values: all outputs 0, key states 0, FSM IDLE, counter 0, `armed` 0, `tog_q` 0.
- Key latency: event at edge N updates key state; the output changes at edge N+1 (2 edges from input).
- Joystick latency: 1 edge.
- Coin latency: `coin_src` rising at edge N gives HOLD at N+1; `btn_coin` is high for exactly `COIN_HOLD` cycles.
- Reset deasserted mid-HOLD: the FSM restarts in IDLE. Because the source is still held, a new full pulse starts, which is acceptable.
- Back-to-back events on consecutive cycles (toggle flips every cycle) are each decoded.
- Counter width: 18 bits, sized for the legal `COIN_HOLD` range.

## Structure
- `pleiads_input_pkg`: scan-code localparams, key-state bit indices, coin FSM state enum.
- Sub-module `coin_pulse_gen`: FSM plus counter, parameterised by `COIN_HOLD`.
- Top level holds the event detector, key-state register, merge logic and output registers.

## Test plan
- Reset with `ps2_key[10]`=1: no key state set; the first decoded event is the next toggle.
- Event `{tog, 1, 9'h06B}` then `{~tog, 1, 9'h16B}`: `btn_left`=1 two edges after the first event and stays 1. Release via `{…, 0, 9'h16B}`: `btn_left`=0 two edges later.
- `COIN_HOLD`=8, `joy[7]` held for 50 cycles: `btn_coin` high for exactly 8 cycles, one pulse. Release, then press again: a second pulse of 8 cycles.
- Key 02E pressed while `joy[7]` is already high in HOLD: still one pulse. `btn_coin` does not re-arm until both sources are released.
- `clear` pulsed while fire and coin are active: `btn_fire`=0 and `btn_coin`=0 on the next edge. `joy[4]`=1 during clear: `btn_fire` stays 1.
- Events with code 9'h129 (extended space) and 9'h0FF: no output changes.

Source files
------------

// File: rtl/pleiads_input_pkg.sv
// Shared definitions for the Pleiads player-input front end.
package pleiads_input_pkg;

  localparam int unsigned KEY_W     = 16;
  localparam int unsigned KEY_IDX_W = 4;
  localparam int unsigned CNT_W     = 18;

  // Key-state bit indices
  localparam int unsigned K_UP         = 0;
  localparam int unsigned K_DOWN       = 1;
  localparam int unsigned K_LEFT       = 2;
  localparam int unsigned K_RIGHT      = 3;
  localparam int unsigned K_CTRL       = 4;
  localparam int unsigned K_FIRE       = 5;
  localparam int unsigned K_START1     = 6;
  localparam int unsigned K_START2     = 7;
  localparam int unsigned K_COIN1      = 8;
  localparam int unsigned K_COIN2      = 9;
  localparam int unsigned K_P2_UP      = 10;
  localparam int unsigned K_P2_DOWN    = 11;
  localparam int unsigned K_P2_LEFT    = 12;
  localparam int unsigned K_P2_RIGHT   = 13;
  localparam int unsigned K_P2_FIRE    = 14;
  localparam int unsigned K_P2_BARRIER = 15;

  // Scan codes matched regardless of the E0 flag
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_CTRL  = 8'h14;

  // Scan codes matched only without the E0 flag
  localparam logic [7:0] SC_SPACE      = 8'h29;
  localparam logic [7:0] SC_START1_A   = 8'h05;
  localparam logic [7:0] SC_START1_B   = 8'h16;
  localparam logic [7:0] SC_START2_A   = 8'h06;
  localparam logic [7:0] SC_START2_B   = 8'h1E;
  localparam logic [7:0] SC_COIN1      = 8'h2E;
  localparam logic [7:0] SC_COIN2      = 8'h36;
  localparam logic [7:0] SC_P2_UP      = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN    = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT    = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT   = 8'h34;
  localparam logic [7:0] SC_P2_FIRE    = 8'h1C;
  localparam logic [7:0] SC_P2_BARRIER = 8'h1B;

  typedef enum logic [1:0] {
    CS_IDLE     = 2'd0,
    CS_HOLD     = 2'd1,
    CS_WAIT_REL = 2'd2
  } coin_state_e;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_sel_t;

  // Map a 9-bit scan code (bit 8 = E0) to a key-state bit
  function automatic key_sel_t decode_key(input logic [8:0] code);
    key_sel_t s;
    s.hit = 1'b1;
    s.idx = '0;
    case (code[7:0])
      SC_UP:    s.idx = KEY_IDX_W'(K_UP);
      SC_DOWN:  s.idx = KEY_IDX_W'(K_DOWN);
      SC_LEFT:  s.idx = KEY_IDX_W'(K_LEFT);
      SC_RIGHT: s.idx = KEY_IDX_W'(K_RIGHT);
      SC_CTRL:  s.idx = KEY_IDX_W'(K_CTRL);
      default: begin
        if (code[8]) begin
          s.hit = 1'b0;
        end else begin
          case (code[7:0])
            SC_SPACE:      s.idx = KEY_IDX_W'(K_FIRE);
            SC_START1_A,
            SC_START1_B:   s.idx = KEY_IDX_W'(K_START1);
            SC_START2_A,
            SC_START2_B:   s.idx = KEY_IDX_W'(K_START2);
            SC_COIN1:      s.idx = KEY_IDX_W'(K_COIN1);
            SC_COIN2:      s.idx = KEY_IDX_W'(K_COIN2);
            SC_P2_UP:      s.idx = KEY_IDX_W'(K_P2_UP);
            SC_P2_DOWN:    s.idx = KEY_IDX_W'(K_P2_DOWN);
            SC_P2_LEFT:    s.idx = KEY_IDX_W'(K_P2_LEFT);
            SC_P2_RIGHT:   s.idx = KEY_IDX_W'(K_P2_RIGHT);
            SC_P2_FIRE:    s.idx = KEY_IDX_W'(K_P2_FIRE);
            SC_P2_BARRIER: s.idx = KEY_IDX_W'(K_P2_BARRIER);
            default:       s.hit = 1'b0;
          endcase
        end
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// Coin pulse shaper: one fixed-width pulse per press of the coin source.
module coin_pulse_gen
  import pleiads_input_pkg::*;
#(
  parameter int unsigned COIN_HOLD = 176000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  input  logic coin_src,
  output logic pulse
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_HOLD - 1);

  coin_state_e      state;
  logic [CNT_W-1:0] cnt;

  // Coin FSM; the pulse is registered alongside the state it belongs to
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= CS_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clear) begin
      state <= CS_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        CS_IDLE: begin
          if (coin_src) begin
            state <= CS_HOLD;
            cnt   <= LOAD;
            pulse <= 1'b1;
          end
        end
        CS_HOLD: begin
          if (cnt == '0) begin
            state <= CS_WAIT_REL;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CS_WAIT_REL: begin
          if (!coin_src) state <= CS_IDLE;
        end
        default: begin
          state <= CS_IDLE;
          pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pleiads_input_ctrl.sv
// Pleiads player input: PS/2 event decode, key state, joystick merge, coin shaping.
module pleiads_input_ctrl
  import pleiads_input_pkg::*;
#(
  parameter int unsigned COIN_HOLD = 176000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_fire,
  output logic        btn_barrier,
  output logic [1:0]  btn_player_start,
  output logic        btn_coin
);

  logic             tog_q;
  logic             armed;
  logic [KEY_W-1:0] keys;
  logic [KEY_W-1:0] key_m;
  key_sel_t         sel;
  logic             ev;
  logic             coin_src;
  logic             unused_bits;

  // Decode the current scan code and detect a toggle event
  always_comb begin
    sel      = decode_key(ps2_key[8:0]);
    ev       = armed && (ps2_key[10] != tog_q);
    key_m    = clear ? '0 : keys;
    coin_src = keys[K_COIN1] | keys[K_COIN2] | joy[7];
  end

  // Event detector and key-state register; first edge after reset/clear only arms
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      armed <= 1'b0;
      keys  <= '0;
    end else if (clear) begin
      armed <= 1'b0;
      keys  <= '0;
    end else if (!armed) begin
      tog_q <= ps2_key[10];
      armed <= 1'b1;
    end else if (ev) begin
      tog_q <= ps2_key[10];
      if (sel.hit) keys[sel.idx] <= ps2_key[9];
    end
  end

  // Merge key states with joystick bits into the registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_left         <= 1'b0;
      btn_right        <= 1'b0;
      btn_fire         <= 1'b0;
      btn_barrier      <= 1'b0;
      btn_player_start <= 2'b00;
    end else begin
      btn_left            <= key_m[K_LEFT]  | key_m[K_P2_LEFT]    | joy[1];
      btn_right           <= key_m[K_RIGHT] | key_m[K_P2_RIGHT]   | joy[0];
      btn_fire            <= key_m[K_FIRE]  | key_m[K_P2_FIRE]    | joy[4];
      btn_barrier         <= key_m[K_CTRL]  | key_m[K_P2_BARRIER] | joy[5];
      btn_player_start[0] <= key_m[K_START1] | joy[5];
      btn_player_start[1] <= key_m[K_START2] | joy[6];
    end
  end

  coin_pulse_gen #(
    .COIN_HOLD (COIN_HOLD)
  ) u_coin (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .clear    (clear),
    .coin_src (coin_src),
    .pulse    (btn_coin)
  );

  // Up/down keys and spare joystick bits are tracked or present but not consumed
  assign unused_bits = ^{joy[15:8], joy[3:2], keys[K_UP], keys[K_DOWN],
                         keys[K_P2_UP], keys[K_P2_DOWN]};

endmodule

// File: tb/tb_pleiads_input_ctrl.sv
// Scoreboard bench for pleiads_input_ctrl with a short coin pulse.
module tb_pleiads_input_ctrl;

  localparam int unsigned HOLD = 8;

  localparam logic [6:0] L  = 7'h01;
  localparam logic [6:0] R  = 7'h02;
  localparam logic [6:0] F  = 7'h04;
  localparam logic [6:0] B  = 7'h08;
  localparam logic [6:0] S1 = 7'h10;
  localparam logic [6:0] S2 = 7'h20;
  localparam logic [6:0] C  = 7'h40;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear   = 1'b0;
  logic [10:0] ps2_key = 11'd0;
  logic [15:0] joy     = 16'd0;
  logic        btn_left, btn_right, btn_fire, btn_barrier, btn_coin;
  logic [1:0]  btn_player_start;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  vec;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned coin_q[$];
  int unsigned cyc    = 0;
  int unsigned run    = 0;
  int          n_total = 0;
  int          n_bad   = 0;
  logic        tg      = 1'b1;
  logic        done    = 1'b0;
  logic [6:0]  outv;

  pleiads_input_ctrl #(.COIN_HOLD(HOLD)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .clear            (clear),
    .ps2_key          (ps2_key),
    .joy              (joy),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_fire         (btn_fire),
    .btn_barrier      (btn_barrier),
    .btn_player_start (btn_player_start),
    .btn_coin         (btn_coin)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Expect the output vector k edges from now
  task automatic exp_at(input int unsigned k, input logic [6:0] v);
    exp_t e;
    e.cyc = cyc + k;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic p, input logic [8:0] code);
    tg      = ~tg;
    ps2_key = {tg, p, code};
  endtask

  // Monitor: output vector scoreboard, coin pulse widths, final summary
  always @(negedge clk_sys) begin
    outv = {btn_coin, btn_player_start, btn_barrier, btn_fire, btn_right, btn_left};
    for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_total++;
        if (exp_q[i].cyc != cyc) begin
          n_bad++;
          $display("FAIL stale_check cyc=%0d target=%0d", cyc, exp_q[i].cyc);
        end else if (outv !== exp_q[i].vec) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, outv, exp_q[i].vec);
        end
        exp_q.delete(i);
      end
    end
    if (btn_coin === 1'b1) begin
      run++;
    end else if (run != 0) begin
      n_total++;
      if (coin_q.size() == 0) begin
        n_bad++;
        $display("FAIL coin_extra_pulse cyc=%0d got_width=%0d want=none", cyc, run);
      end else begin
        int unsigned w;
        w = coin_q.pop_front();
        if (w != run) begin
          n_bad++;
          $display("FAIL coin_width cyc=%0d got=%0d want=%0d", cyc, run, w);
        end
      end
      run = 0;
    end
    if (done) begin
      n_total++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL unchecked_expects got=%0d want=0", exp_q.size());
      end
      n_total++;
      if (coin_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_coin_pulses got=%0d want=0", coin_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with toggle high and a left press pending: arm edge must not decode it
    ps2_key = {1'b1, 1'b1, 9'h06B};
    tick(2);
    exp_at(0, 7'h00);
    reset_n = 1'b1;
    exp_at(1, 7'h00);
    exp_at(2, 7'h00);
    tick(3);

    // Left press, then extended left press back-to-back, then release
    send(1'b1, 9'h06B);
    exp_at(1, 7'h00);
    exp_at(2, L);
    tick();
    send(1'b1, 9'h16B);
    exp_at(3, L);
    tick(4);
    send(1'b0, 9'h16B);
    exp_at(1, L);
    exp_at(2, 7'h00);
    tick(3);

    // Back-to-back fire, start1, start2 presses and alternate-code releases
    send(1'b1, 9'h029); exp_at(2, F);            tick();
    send(1'b1, 9'h005); exp_at(2, F | S1);       tick();
    send(1'b1, 9'h01E); exp_at(2, F | S1 | S2);  tick();
    send(1'b0, 9'h029); exp_at(2, S1 | S2);      tick();
    send(1'b0, 9'h016); exp_at(2, S2);           tick();
    send(1'b0, 9'h006); exp_at(2, 7'h00);        tick(4);

    // Extended right and P2 left, then releases
    send(1'b1, 9'h174); exp_at(2, R);            tick();
    send(1'b1, 9'h023); exp_at(2, R | L);        tick();
    send(1'b0, 9'h074); exp_at(2, L);            tick();
    send(1'b0, 9'h023); exp_at(2, 7'h00);        tick(4);

    // Extended ctrl (barrier) and P2 barrier
    send(1'b1, 9'h114); exp_at(2, B);            tick(3);
    send(1'b1, 9'h01B); exp_at(2, B);            tick();
    send(1'b0, 9'h014); exp_at(2, B);            tick();
    send(1'b0, 9'h01B); exp_at(2, 7'h00);        tick(4);

    // Ignored codes: extended space and unmapped code
    send(1'b1, 9'h129); exp_at(2, 7'h00);        tick();
    send(1'b1, 9'h0FF); exp_at(2, 7'h00); exp_at(4, 7'h00); tick(5);

    // Joystick terms, one edge latency
    joy = 16'h0021; exp_at(0, 7'h00); exp_at(1, R | B | S1); tick(2);
    joy = 16'h0042; exp_at(1, L | S2);           tick(2);
    joy = 16'h0010; exp_at(1, F);                tick(2);
    joy = 16'h0000; exp_at(1, 7'h00);            tick(3);

    // joy[7] held long: one pulse of HOLD cycles
    joy = 16'h0080;
    coin_q.push_back(HOLD);
    exp_at(0, 7'h00); exp_at(1, C); exp_at(HOLD, C); exp_at(HOLD + 1, 7'h00);
    exp_at(40, 7'h00);
    tick(50);
    joy = 16'h0000; tick(3);
    joy = 16'h0080;
    coin_q.push_back(HOLD);
    exp_at(1, C); exp_at(HOLD, C); exp_at(HOLD + 1, 7'h00);
    tick(20);
    joy = 16'h0000; tick(3);

    // Key coin pressed during HOLD from joy[7]: still one pulse, no re-arm until both release
    joy = 16'h0080;
    coin_q.push_back(HOLD);
    tick(3);
    send(1'b1, 9'h02E);
    tick(20);
    joy = 16'h0000;
    exp_at(2, 7'h00);
    tick(5);
    send(1'b0, 9'h02E);
    exp_at(3, 7'h00);
    tick(4);
    send(1'b1, 9'h02E);
    coin_q.push_back(HOLD);
    exp_at(1, 7'h00); exp_at(2, C); exp_at(HOLD + 1, C); exp_at(HOLD + 2, 7'h00);
    tick(12);
    send(1'b0, 9'h02E);
    tick(4);

    // Clear while fire key and coin pulse are active
    send(1'b1, 9'h029);
    exp_at(2, F);
    tick(3);
    joy = 16'h0080;
    exp_at(1, F | C);
    tick(3);
    clear = 1'b1;
    joy   = 16'h0000;
    coin_q.push_back(3);
    exp_at(0, F | C);
    exp_at(1, 7'h00);
    tick();
    clear = 1'b0;
    exp_at(2, 7'h00);
    tick();
    // Re-armed; press fire again, then clear with joy[4] held
    send(1'b1, 9'h029);
    exp_at(1, 7'h00);
    exp_at(2, F);
    tick(3);
    clear = 1'b1;
    joy   = 16'h0010;
    exp_at(1, F);
    tick();
    clear = 1'b0;
    exp_at(0, F);
    exp_at(1, F);
    tick(2);
    joy = 16'h0000;
    exp_at(1, 7'h00);
    tick(3);

    done = 1'b1;
  end

endmodule
